// File: rtl/uart_calc_interface.sv
// Calculator front end: parses "A op B <ENTER>" from RX bytes, drives the ALU,
// and returns the signed decimal result plus CR through the TX handshake.
// Latency: first TX_START 6 cycles after the ENTER byte. Backpressure: each reply
// byte waits for TX_DONE before the next. RX bytes outside GET_A/GET_B are dropped.
// Ports: CLK/RESET (sync, active-high); RX_DATA/RX_DONE from the receiver;
//   ALU_A/ALU_B/ALU_OP to the ALU, ALU_RESULT back; TX_DATA/TX_START/TX_DONE
//   to the transmitter; LEDS = last result; ERROR = last expression failed to parse.
module uart_calc_interface #(
  parameter int         NB_OP      = 6,
  parameter int         MAX_DIGITS = 3,
  parameter logic [7:0] ENTER_CHAR = 8'h0D
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       RX_DATA,
  input  logic             RX_DONE,
  input  logic [7:0]       ALU_RESULT,
  output logic [7:0]       ALU_A,
  output logic [7:0]       ALU_B,
  output logic [NB_OP-1:0] ALU_OP,
  output logic [7:0]       TX_DATA,
  output logic             TX_START,
  input  logic             TX_DONE,
  output logic [7:0]       LEDS,
  output logic             ERROR
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  localparam logic [2:0] GET_A = 3'd0;
  localparam logic [2:0] GET_B = 3'd1;
  localparam logic [2:0] EXEC  = 3'd2;
  localparam logic [2:0] CONV  = 3'd3;
  localparam logic [2:0] SEND  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic          neg;
  logic          hund;
  logic [3:0]    tens;
  logic [7:0]    rem;
  logic [1:0]    step;
  logic [2:0]    idx;
  logic          tx_wait;

  logic          is_digit;
  logic          op_valid;
  logic [5:0]    op_code;
  logic [7:0]    digit;
  logic [7:0]    mag;
  logic [7:0]    reply [8];
  logic [2:0]    wr_pos;
  logic [7:0]    cur_byte;
  logic          sending;

  assign is_digit = (RX_DATA >= 8'h30) && (RX_DATA <= 8'h39);
  assign digit    = {4'd0, RX_DATA[3:0]};
  // Magnitude of the signed result; 0x80 maps to 128, which still fits unsigned.
  assign mag      = ALU_RESULT[7] ? (~ALU_RESULT + 8'd1) : ALU_RESULT;

  always_comb begin
    op_valid = 1'b1;
    op_code  = 6'b000000;
    case (RX_DATA)
      8'h2B:   op_code = 6'b100000;
      8'h2D:   op_code = 6'b100010;
      8'h26:   op_code = 6'b100100;
      8'h7C:   op_code = 6'b100101;
      8'h5E:   op_code = 6'b100110;
      8'h7E:   op_code = 6'b100111;
      8'h3E:   op_code = 6'b000011;
      8'h3C:   op_code = 6'b000010;
      default: op_valid = 1'b0;
    endcase
  end

  // Reply buffer packed from the conversion registers: [-] [h] [t] o CR.
  always_comb begin
    for (int i = 0; i < 8; i++) reply[i] = ENTER_CHAR;
    wr_pos = 3'd0;
    if (neg) begin
      reply[wr_pos] = 8'h2D;
      wr_pos = wr_pos + 3'd1;
    end
    if (hund) begin
      reply[wr_pos] = 8'h31;
      wr_pos = wr_pos + 3'd1;
    end
    if (hund || (tens != 4'd0)) begin
      reply[wr_pos] = 8'h30 + {4'd0, tens};
      wr_pos = wr_pos + 3'd1;
    end
    reply[wr_pos] = 8'h30 + {4'd0, rem[3:0]};
    wr_pos = wr_pos + 3'd1;
    reply[wr_pos] = ENTER_CHAR;
  end

  assign sending  = (state == SEND) || (state == ERR);
  assign cur_byte = (state == ERR) ? ((idx == 3'd0) ? 8'h3F : ENTER_CHAR) : reply[idx];
  assign TX_DATA  = sending ? cur_byte : 8'h00;
  // TX_START is high only in the first cycle a byte is presented.
  assign TX_START = sending && !tx_wait;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= GET_A;
      cnt_a   <= '0;
      cnt_b   <= '0;
      ALU_A   <= 8'h00;
      ALU_B   <= 8'h00;
      ALU_OP  <= '0;
      LEDS    <= 8'h00;
      ERROR   <= 1'b0;
      neg     <= 1'b0;
      hund    <= 1'b0;
      tens    <= 4'd0;
      rem     <= 8'h00;
      step    <= 2'd0;
      idx     <= 3'd0;
      tx_wait <= 1'b0;
    end else begin
      case (state)
        GET_A: if (RX_DONE) begin
          if (cnt_a == '0) ERROR <= 1'b0;
          if (is_digit && (cnt_a != CW'(MAX_DIGITS))) begin
            ALU_A <= (ALU_A << 3) + (ALU_A << 1) + digit;
            cnt_a <= cnt_a + CW'(1);
          end else if (op_valid && !is_digit && (cnt_a != '0)) begin
            ALU_OP <= NB_OP'(op_code);
            state  <= GET_B;
          end else begin
            ERROR <= 1'b1;
            state <= ERR;
          end
        end
        GET_B: if (RX_DONE) begin
          if (is_digit && (cnt_b != CW'(MAX_DIGITS))) begin
            ALU_B <= (ALU_B << 3) + (ALU_B << 1) + digit;
            cnt_b <= cnt_b + CW'(1);
          end else if ((RX_DATA == ENTER_CHAR) && (cnt_b != '0)) begin
            state <= EXEC;
          end else begin
            ERROR <= 1'b1;
            state <= ERR;
          end
        end
        EXEC: begin
          LEDS  <= ALU_RESULT;
          neg   <= ALU_RESULT[7];
          rem   <= mag;
          hund  <= 1'b0;
          tens  <= 4'd0;
          step  <= 2'd0;
          state <= CONV;
        end
        // Four fixed steps, one subtraction each: 100 (else 80), then 40, 20, 10.
        // Binary-weighted tens keep the reply latency constant at 6 cycles.
        CONV: begin
          step <= step + 2'd1;
          case (step)
            2'd0: begin
              if (rem >= 8'd100) begin
                rem  <= rem - 8'd100;
                hund <= 1'b1;
              end else if (rem >= 8'd80) begin
                rem  <= rem - 8'd80;
                tens <= 4'd8;
              end
            end
            2'd1: if (rem >= 8'd40) begin
              rem  <= rem - 8'd40;
              tens <= tens + 4'd4;
            end
            2'd2: if (rem >= 8'd20) begin
              rem  <= rem - 8'd20;
              tens <= tens + 4'd2;
            end
            default: begin
              if (rem >= 8'd10) begin
                rem  <= rem - 8'd10;
                tens <= tens + 4'd1;
              end
              state <= SEND;
            end
          endcase
        end
        SEND, ERR: begin
          // A TX_DONE in the TX_START cycle is ignored: tx_wait is still low.
          if (!tx_wait) begin
            tx_wait <= 1'b1;
          end else if (TX_DONE) begin
            tx_wait <= 1'b0;
            if (cur_byte == ENTER_CHAR) begin
              idx   <= 3'd0;
              ALU_A <= 8'h00;
              ALU_B <= 8'h00;
              cnt_a <= '0;
              cnt_b <= '0;
              if (state == SEND) ALU_OP <= '0;
              state <= GET_A;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_calc_interface.sv
// Bench for uart_calc_interface: directed expressions, parse errors and
// reset/RX interference, with a bench ALU model, a transmitter model that
// answers TX_START with a delayed TX_DONE, and a byte scoreboard.
module tb_uart_calc_interface;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] RX_DATA;
  logic       RX_DONE;
  logic [7:0] ALU_RESULT;
  logic [7:0] ALU_A;
  logic [7:0] ALU_B;
  logic [5:0] ALU_OP;
  logic [7:0] TX_DATA;
  logic       TX_START;
  logic       TX_DONE;
  logic [7:0] LEDS;
  logic       ERROR;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;

  logic [7:0] sb [$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  busy   = 1'b0;
  bit  abort  = 1'b0;
  bit  glitch = 1'b0;

  always #5 CLK = ~CLK;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      6'b100000: alu_f = a + b;
      6'b100010: alu_f = a - b;
      6'b100100: alu_f = a & b;
      6'b100101: alu_f = a | b;
      6'b100110: alu_f = a ^ b;
      6'b100111: alu_f = ~(a | b);
      6'b000011: alu_f = $signed(a) >>> b;
      6'b000010: alu_f = a >> b;
      default:   alu_f = 8'h00;
    endcase
  endfunction

  assign ALU_RESULT = alu_f(ALU_A, ALU_B, ALU_OP);

  uart_calc_interface dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .RX_DATA    (RX_DATA),
    .RX_DONE    (RX_DONE),
    .ALU_RESULT (ALU_RESULT),
    .ALU_A      (ALU_A),
    .ALU_B      (ALU_B),
    .ALU_OP     (ALU_OP),
    .TX_DATA    (TX_DATA),
    .TX_START   (TX_START),
    .TX_DONE    (TX_DONE),
    .LEDS       (LEDS),
    .ERROR      (ERROR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Transmitter model and scoreboard consumer.
  initial begin
    logic [7:0] exp_b;
    TX_DONE = 1'b0;
    forever begin
      if (TX_START === 1'b1) begin
        check("tx_pending", (sb.size() != 0), 1);
        if (sb.size() != 0) exp_b = sb.pop_front();
        else exp_b = 8'h00;
        check("tx_byte", TX_DATA, exp_b);
        TX_DONE = glitch;
        busy    = 1'b1;
        @(negedge CLK);
        TX_DONE = 1'b0;
        check("tx_start_pulse", TX_START, 0);
        repeat ($urandom_range(2, 4)) @(negedge CLK);
        if (!abort) check("tx_data_hold", TX_DATA, exp_b);
        TX_DONE = 1'b1;
        @(negedge CLK);
        TX_DONE = 1'b0;
        busy    = 1'b0;
      end else begin
        @(negedge CLK);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send_char(input logic [7:0] c);
    @(negedge CLK);
    RX_DATA = c;
    RX_DONE = 1'b1;
    @(negedge CLK);
    RX_DONE = 1'b0;
  endtask

  task automatic push_reply(input logic [7:0] r);
    string s;
    s = $sformatf("%0d", $signed(r));
    for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
    sb.push_back(8'h0D);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 400) begin
      @(negedge CLK);
      k++;
    end
    check({tag, " reply_done"}, (k < 400), 1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic expr(input string s, input logic [7:0] a, input logic [7:0] b,
                      input logic [5:0] op, input logic [7:0] r);
    int k;
    push_reply(r);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    send_char(8'h0D);
    check({s, " alu_a"}, ALU_A, a);
    check({s, " alu_b"}, ALU_B, b);
    check({s, " alu_op"}, ALU_OP, op);
    k = 1;
    while (!TX_START && k < 8) begin
      @(negedge CLK);
      k++;
    end
    check({s, " latency_le6"}, (k <= 6), 1);
    wait_idle(s);
    check({s, " leds"}, LEDS, r);
    check({s, " error"}, ERROR, 0);
    check({s, " op_cleared"}, ALU_OP, 0);
    check({s, " a_cleared"}, ALU_A, 0);
  endtask

  task automatic err_case(input string s);
    sb.push_back(8'h3F);
    sb.push_back(8'h0D);
    for (int i = 0; i < s.len(); i++) begin
      if (i == s.len() - 1 && i > 0) check({s, " error_before_last"}, ERROR, 0);
      send_char(s[i]);
    end
    check({s, " error_set"}, ERROR, 1);
    wait_idle(s);
    check({s, " error_held"}, ERROR, 1);
    check({s, " a_cleared"}, ALU_A, 0);
  endtask

  initial begin
    int k;
    int starts;
    RESET   = 1'b1;
    RX_DONE = 1'b0;
    RX_DATA = 8'h00;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check("rst alu_a", ALU_A, 0);
    check("rst alu_b", ALU_B, 0);
    check("rst alu_op", ALU_OP, 0);
    check("rst tx_data", TX_DATA, 0);
    check("rst tx_start", TX_START, 0);
    check("rst leds", LEDS, 0);
    check("rst error", ERROR, 0);

    expr("2-1", 8'd2, 8'd1, OP_SUB, 8'h01);
    glitch = 1'b1;
    expr("2+2", 8'd2, 8'd2, OP_ADD, 8'h04);
    glitch = 1'b0;
    expr("1-2", 8'd1, 8'd2, OP_SUB, 8'hFF);
    expr("100+100", 8'd100, 8'd100, OP_ADD, 8'hC8);
    expr("127+1", 8'd127, 8'd1, OP_ADD, 8'h80);
    expr("12&10", 8'd12, 8'd10, OP_AND, 8'h08);
    expr("200>2", 8'd200, 8'd2, OP_SRA, 8'hF2);
    expr("9~0", 8'd9, 8'd0, OP_NOR, 8'hF6);
    expr("0+0", 8'd0, 8'd0, OP_ADD, 8'h00);

    err_case("2x");
    err_case("1234");
    err_case("+");
    expr("5+0", 8'd5, 8'd0, OP_ADD, 8'h05);

    // Reset one cycle after the first TX_START of a three-byte reply.
    sb.push_back(8'h2D);
    send_char("1");
    send_char("-");
    send_char("2");
    send_char(8'h0D);
    k = 0;
    while (!TX_START && k < 10) begin
      @(negedge CLK);
      k++;
    end
    check("midsend first_start", TX_START, 1);
    @(negedge CLK);
    abort = 1'b1;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("midsend alu_a", ALU_A, 0);
    check("midsend alu_b", ALU_B, 0);
    check("midsend alu_op", ALU_OP, 0);
    check("midsend tx_data", TX_DATA, 0);
    check("midsend tx_start", TX_START, 0);
    check("midsend leds", LEDS, 0);
    check("midsend error", ERROR, 0);
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (TX_START) starts++;
    end
    check("midsend no_tx_after_reset", starts, 0);
    k = 0;
    while (busy && k < 50) begin
      @(negedge CLK);
      k++;
    end
    abort = 1'b0;
    check("midsend sb_empty", sb.size(), 0);
    expr("5+0", 8'd5, 8'd0, OP_ADD, 8'h05);

    // RX bytes arriving during CONV and SEND must not disturb the reply.
    push_reply(8'h06);
    send_char("3");
    send_char("+");
    send_char("3");
    send_char(8'h0D);
    send_char("7");
    k = 0;
    while (!busy && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check("inject reply_started", busy, 1);
    send_char("9");
    send_char(8'h0D);
    wait_idle("inject");
    check("inject leds", LEDS, 8'h06);
    check("inject error", ERROR, 0);
    check("inject a_cleared", ALU_A, 0);
    expr("2-1", 8'd2, 8'd1, OP_SUB, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_calc_interface.md
Name: uart_calc_interface

Overview:
- Sits between the UART receiver and the UART transmitter in the TP2 calculator top level; also drives the combinational ALU.
- Parses an ASCII expression from RX bytes: decimal operand A, an operator character, decimal operand B, then ENTER (0x0D).
- Presents the operands and opcode to the ALU, then latches the 8-bit result.
- Returns the result as signed decimal ASCII followed by CR, one byte at a time, through the transmitter handshake.

Parameters:
- NB_OP, 6: ALU opcode width.
- MAX_DIGITS, 3: maximum decimal digits per operand.
- ENTER_CHAR, 8'h0D: character that terminates the expression.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- RX_DATA  in  8  byte from the UART receiver.
- RX_DONE  in  1  one-cycle pulse; RX_DATA is valid in that cycle.
- ALU_RESULT  in  8  combinational ALU output.
- ALU_A  out  8  operand A.
- ALU_B  out  8  operand B.
- ALU_OP  out  NB_OP  opcode.
- TX_DATA  out  8  byte to the transmitter.
- TX_START  out  1  one-cycle pulse requesting transmission of TX_DATA.
- TX_DONE  in  1  one-cycle pulse from the transmitter when a byte has finished.
- LEDS  out  8  last latched result.
- ERROR  out  1  set on a parse error; cleared at the start of the next expression.

Behaviour:
- Reset values: every output is 0, including ALU_OP=6'b000000. FSM goes to GET_A. Digit counters and operand accumulators are cleared. RESET has priority in every state, including mid-send; any byte in flight is abandoned.
- Characters are consumed only in cycles where RX_DONE=1.
- Digits are '0'..'9' (0x30..0x39). Accumulation is acc <= acc*10 + digit, modulo 256. A digit is counted toward the MAX_DIGITS limit.
- Operator map:
  - '+' -> 100000 (ADD)
  - '-' -> 100010 (SUB)
  - '&' -> 100100 (AND)
  - '|' -> 100101 (OR)
  - '^' -> 100110 (XOR)
  - '~' -> 100111 (NOR)
  - '>' -> 000011 (SRA)
  - '<' -> 000010 (SRL)
- GET_A:
  - First char of a new expression clears ERROR and LEDS is retained.
  - A digit accumulates into ALU_A.
  - An operator moves to GET_B, but only if at least one digit was received; the opcode is latched into ALU_OP.
  - Anything else moves to ERR.
- GET_B:
  - A digit accumulates into ALU_B.
  - ENTER_CHAR moves to EXEC, but only if B has at least one digit.
  - Anything else moves to ERR.
- Digit overflow: a (MAX_DIGITS+1)-th digit in either operand moves to ERR.
- EXEC: lasts exactly 1 cycle. ALU_RESULT is sampled at the end of this cycle into res and LEDS, then the FSM moves to CONV. Operands and opcode stay stable through EXEC.
- CONV:
  - Treat res as signed two's complement.
  - Build the output buffer: an optional '-' (0x2D); then the magnitude (0..128) as decimal with no leading zeros ("0" for zero); then 0x0D.
  - Digits are produced by sequential repeated subtraction of 100, then 10; one subtraction per cycle is allowed.
  - Buffer length is 2..5 bytes.
  - On completion, move to SEND.
- SEND:
  - For each buffered byte: drive TX_DATA and pulse TX_START for exactly 1 cycle, then wait for TX_DONE.
  - TX_DATA holds until TX_DONE.
  - After the TX_DONE of the final CR: clear the operands, counters and ALU_OP, then return to GET_A.
- ERR:
  - Set ERROR=1.
  - Send '?' (0x3F) then 0x0D using the same handshake as SEND.
  - Clear operands and counters, then return to GET_A.
- RX_DONE during EXEC, CONV, SEND or ERR: the byte is dropped silently, with no state change.
- TX_DONE arriving in the same cycle as TX_START: ignored. A byte is complete only on a TX_DONE strictly after its TX_START.
- Latency: TX_START for the first byte occurs at most 6 cycles after the RX_DONE carrying ENTER.

Test Plan:
- "2","-","1",CR -> ALU_A=2, ALU_B=1, ALU_OP=100010; ALU model returns 0x01 -> TX bytes 0x31, 0x0D; LEDS=0x01; ERROR=0.
- "2","+","2",CR -> ALU_OP=100000; TX 0x34, 0x0D; LEDS=0x04.
- "1","-","2",CR -> result 0xFF -> TX 0x2D, 0x31, 0x0D; LEDS=0xFF.
- "100","+","100",CR -> result 0xC8 (-56) -> TX 0x2D, 0x35, 0x36, 0x0D. Separately, "127","+","1",CR -> TX 0x2D, 0x31, 0x32, 0x38, 0x0D.
- Error cases:
  - "2","x" -> ERROR=1; TX 0x3F, 0x0D.
  - "1234" -> ERR on the 4th digit.
  - "+" as the first char -> ERR.
  - After any of these, "5","+","0",CR -> ERROR clears; TX 0x35, 0x0D.
- Reset mid-send: assert RESET after the first TX_START of a multi-byte reply -> next cycle all outputs are 0 and FSM is in GET_A; no further TX_START. Also, RX bytes injected during SEND -> ignored, and the reply is unchanged.
